// File: rtl/pio_cmd_master.sv
// Single-outstanding AXI4-style PIO master: turns one command into an AR/R or
// AW+W/B exchange with a per-phase handshake timeout, then returns a response.
module pio_cmd_master #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 1024,
  parameter int TIMEOUT = 1024
) (
  input  logic              axi4_mm_clk,
  input  logic              axi4_mm_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  output logic              rready,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  input  logic              awready,
  output logic              wvalid,
  output logic [DATA_W-1:0] wdata,
  input  logic              bvalid,
  output logic              bready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_B, S_RSP} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic [31:0]         rd_cnt_q, rd_cnt_d;
  logic [31:0]         wr_cnt_q, wr_cnt_d;
  logic                expired;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    wait_d   = wait_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    expired  = (wait_q == WAIT_LAST);
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          write_d = cmd_write;
          err_d   = 1'b0;
          rdata_d = '0;
          wait_d  = '0;
          if (cmd_addr[7:0] != 8'h00) begin
            err_d   = 1'b1;
            state_d = S_RSP;
          end else begin
            state_d = cmd_write ? S_AW : S_AR;
          end
        end
      end
      // Each bus phase: handshake wins over an expiring wait counter.
      S_AR: begin
        if (arready) begin
          state_d = S_R;
          wait_d  = '0;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_RSP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_R: begin
        if (rvalid) begin
          rdata_d = rdata;
          state_d = S_RSP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_RSP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_AW: begin
        if (awready) begin
          state_d = S_B;
          wait_d  = '0;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_RSP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_B: begin
        if (bvalid) begin
          state_d = S_RSP;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = S_RSP;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
          if (!err_q) begin
            if (write_q) wr_cnt_d = wr_cnt_q + 32'd1;
            else         rd_cnt_d = rd_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi4_mm_clk or posedge axi4_mm_rst) begin
    if (axi4_mm_rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      wait_q   <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      wait_q   <= wait_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // IDLE is the reset state, so cmd_ready is also masked while reset is held.
  assign cmd_ready = (state_q == S_IDLE) && !axi4_mm_rst;
  assign arvalid   = (state_q == S_AR);
  assign rready    = (state_q == S_R);
  assign awvalid   = (state_q == S_AW);
  assign wvalid    = (state_q == S_AW);
  assign bready    = (state_q == S_B);
  assign rsp_valid = (state_q == S_RSP);
  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign wdata     = wdata_q;
  assign rsp_write = write_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;
  assign rd_count  = rd_cnt_q;
  assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_pio_cmd_master.sv
// Randomised scoreboard bench for pio_cmd_master with a delay-programmable
// downstream memory and a reference model derived from the command rules.
module tb_pio_cmd_master;
  localparam int AW = 64;
  localparam int DW = 128;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          arvalid, rready, awvalid, wvalid, bready;
  logic [AW-1:0] araddr, awaddr;
  logic [DW-1:0] wdata;
  logic          arready = 1'b0, rvalid = 1'b0, awready = 1'b0, bvalid = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          rsp_valid, rsp_ready = 1'b1, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [31:0]   rd_count, wr_count;

  pio_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .axi4_mm_clk(clk), .axi4_mm_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .bvalid(bvalid), .bready(bready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          write;
    logic          err;
    logic [DW-1:0] rdata;
    int            first_cyc;
  } exp_t;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            d1;
    int            d2;
  } bus_t;

  exp_t          sb_q[$];
  bus_t          bus_q[$];
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [31:0]   exp_rd = '0, exp_wr = '0;
  int            n_cmp = 0, n_bad = 0;
  int            hold_cnt = 0;
  bit            rdy_random = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    logic [31:0] s;
    if (mem.exists(a)) return mem[a];
    s = a[31:0] ^ 32'h5A5A_1234;
    return {s, ~s, s + 32'd7, s ^ 32'hFFFF_0000};
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Driver: issue one command and push its expected response.
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input int d1, input int d2);
    exp_t e;
    bus_t b;
    int   n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      fail("cmd_accept_timeout");
      cmd_valid = 1'b0;
      return;
    end
    e.write = w;
    e.rdata = '0;
    if (a[7:0] != 8'h00) begin
      e.err = 1'b1;
      e.first_cyc = cyc + 1;
    end else begin
      b.write = w; b.addr = a; b.wdata = d; b.d1 = d1; b.d2 = d2;
      bus_q.push_back(b);
      if (d1 >= TO) begin
        e.err = 1'b1;
        e.first_cyc = cyc + 1 + TO;
      end else if (d2 >= TO) begin
        e.err = 1'b1;
        e.first_cyc = cyc + 1 + (d1 + 1) + TO;
      end else begin
        e.err = 1'b0;
        e.rdata = w ? '0 : mem_rd(a);
        e.first_cyc = cyc + d1 + d2 + 3;
      end
    end
    sb_q.push_back(e);
    $display("cmd  t=%0t write=%0d addr=%h d1=%0d d2=%0d err=%0d", $time, w, a, d1, d2, e.err);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || rsp_valid || !cmd_ready) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      fail("drain_timeout");
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Downstream memory: each phase answers after its programmed number of wait cycles.
  initial begin
    bus_t cur;
    int   ca, cr, cw, cb;
    logic pa, pr, pw, pb, have;
    ca = 0; cr = 0; cw = 0; cb = 0;
    pa = 0; pr = 0; pw = 0; pb = 0; have = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        arready = 0; rvalid = 0; awready = 0; bvalid = 0;
        pa = 0; pr = 0; pw = 0; pb = 0; have = 0;
        continue;
      end
      if (arvalid || awvalid) begin
        if (!pa && !pw) begin
          if (bus_q.size() == 0) begin
            fail("unexpected_bus_request");
            have = 0;
          end else begin
            cur = bus_q.pop_front();
            have = 1;
          end
          ca = 0; cw = 0;
        end
      end
      if (arvalid) begin
        if (have) begin
          chk("araddr", DW'(araddr), DW'(cur.addr));
          arready = (ca == cur.d1);
        end else arready = 0;
        ca++;
      end else begin
        if (pa && have) chk("ar_cycles", DW'(ca), DW'(min_i(cur.d1 + 1, TO)));
        arready = 0;
      end
      if (rready) begin
        if (!pr) cr = 0;
        rvalid = have && !cur.write && (cr == cur.d2);
        rdata = have ? mem_rd(cur.addr) : '0;
        cr++;
      end else begin
        if (pr && have) chk("r_cycles", DW'(cr), DW'(min_i(cur.d2 + 1, TO)));
        rvalid = 0;
      end
      if (awvalid) begin
        if (have) begin
          chk("awaddr", DW'(awaddr), DW'(cur.addr));
          chk("wvalid", DW'(wvalid), DW'(1'b1));
          chk("wdata", wdata, cur.wdata);
          awready = (cw == cur.d1);
          if (awready) mem[cur.addr] = cur.wdata;
        end else awready = 0;
        cw++;
      end else begin
        if (pw && have) chk("aw_cycles", DW'(cw), DW'(min_i(cur.d1 + 1, TO)));
        awready = 0;
      end
      if (bready) begin
        if (!pb) cb = 0;
        bvalid = have && cur.write && (cb == cur.d2);
        cb++;
      end else begin
        if (pb && have) chk("b_cycles", DW'(cb), DW'(min_i(cur.d2 + 1, TO)));
        bvalid = 0;
      end
      pa = arvalid; pr = rready; pw = awvalid; pb = bready;
    end
  end

  // Response sink: optional forced back-pressure, otherwise random or always ready.
  initial begin
    forever begin
      @(negedge clk);
      if (hold_cnt > 0 && rsp_valid) begin
        rsp_ready = 1'b0;
        hold_cnt--;
      end else if (rdy_random) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rsp_ready = 1'b1;
      end
    end
  end

  // Monitor: compares every presented response against the scoreboard head.
  initial begin
    exp_t e;
    logic seen, cnt_pend;
    seen = 0; cnt_pend = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        seen = 0; cnt_pend = 0;
        continue;
      end
      if (cnt_pend) begin
        chk("rd_count", DW'(rd_count), DW'(exp_rd));
        chk("wr_count", DW'(wr_count), DW'(exp_wr));
        cnt_pend = 0;
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          if (!seen) fail("unexpected_rsp");
          seen = !rsp_ready;
        end else begin
          e = sb_q[0];
          if (!seen) chk("rsp_latency_cycle", DW'(cyc), DW'(e.first_cyc));
          seen = 1;
          chk("rsp_write", DW'(rsp_write), DW'(e.write));
          chk("rsp_err", DW'(rsp_err), DW'(e.err));
          chk("rsp_rdata", rsp_rdata, e.rdata);
          if (rsp_ready) begin
            void'(sb_q.pop_front());
            seen = 0;
            if (!e.err) begin
              if (e.write) exp_wr = exp_wr + 32'd1;
              else         exp_rd = exp_rd + 32'd1;
            end
            cnt_pend = 1;
            $display("rsp  t=%0t write=%0d err=%0d rdata=%h", $time, rsp_write, rsp_err, rsp_rdata);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] pat, dat;
    logic [AW-1:0] a;
    int            n, d1, d2, r;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_cmd_ready", DW'(cmd_ready), '0);
    chk("reset_bus_valids", DW'({arvalid, rready, awvalid, wvalid, bready}), '0);
    chk("reset_rsp_valid", DW'(rsp_valid), '0);
    chk("reset_rsp_err", DW'(rsp_err), '0);
    chk("reset_rsp_rdata", rsp_rdata, '0);
    chk("reset_counts", DW'({rd_count, wr_count}), '0);
    @(negedge clk);
    rst = 1'b0;

    // Aligned read, immediate downstream
    pat = {$urandom, $urandom, $urandom, $urandom};
    mem[64'h300] = pat;
    issue(1'b0, 64'h300, '0, 0, 0);
    wait_idle();

    // Write with delayed awready, then read it back
    dat = {$urandom, $urandom, $urandom, $urandom};
    issue(1'b1, 64'h1F00, dat, 5, 2);
    wait_idle();
    issue(1'b0, 64'h1F00, '0, 1, 0);
    wait_idle();

    // Misaligned read
    issue(1'b0, 64'h104, '0, 0, 0);
    wait_idle();

    // AR timeout, then held response
    hold_cnt = 4;
    issue(1'b0, 64'h500, '0, 1000, 0);
    wait_idle();

    // Reset while waiting in B
    issue(1'b1, 64'h700, {$urandom, $urandom, $urandom, $urandom}, 0, 1000);
    n = 0;
    while (!bready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bready) fail("reach_b_state");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_bready_drop", DW'(bready), '0);
    chk("rst_no_rsp", DW'(rsp_valid), '0);
    chk("rst_counts_zero", DW'({rd_count, wr_count}), '0);
    sb_q.delete();
    bus_q.delete();
    exp_rd = '0;
    exp_wr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    issue(1'b0, 64'h300, '0, 0, 0);
    wait_idle();

    // Randomised traffic, including handshake on the last wait cycle
    rdy_random = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = AW'($urandom_range(0, 7)) << 8;
      if ($urandom_range(0, 7) == 0) a[7:0] = 8'($urandom_range(1, 255));
      r = $urandom_range(0, 9);
      d1 = (r == 0) ? TO - 1 : (r == 1) ? TO : $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      d2 = (r == 0) ? TO - 1 : (r == 1) ? TO + 2 : $urandom_range(0, 3);
      issue(1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom}, d1, d2);
    end
    wait_idle();
    rdy_random = 1'b0;

    // Write counter wrap
    @(negedge clk);
    force dut.wr_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.wr_cnt_q;
    exp_wr = 32'hFFFF_FFFF;
    #1;
    chk("wr_count_preset", DW'(wr_count), DW'(exp_wr));
    issue(1'b1, 64'h200, {$urandom, $urandom, $urandom, $urandom}, 0, 0);
    wait_idle();
    #1;
    chk("wr_count_wrap", DW'(wr_count), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
